// File: rtl/pwm_audio_dac.sv
// pwm_audio_dac: double-buffered single-bit PWM audio output stage with overrun/underrun status
module pwm_audio_dac #(
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 pwm_out,
    output logic                 period_start,
    output logic                 overrun,
    output logic                 underrun
);
    localparam logic [DATA_BITS-1:0] MIDSCALE = {1'b1, {(DATA_BITS-1){1'b0}}};
    logic [DATA_BITS-1:0] cnt, duty, pend, duty_nx, pend_nx;
    logic                 pend_full, pend_full_nx, boundary, overrun_nx, underrun_nx;
    // Boundary promotes the pending sample, or bypasses a strobe that lands on it; elsewhere a strobe fills the buffer
    always_comb begin
        boundary     = &cnt;
        duty_nx      = boundary ? (pend_full ? pend : (din_valid ? din : duty)) : duty;
        pend_nx      = (din_valid && (!boundary || pend_full)) ? din : pend;
        pend_full_nx = boundary ? (pend_full & din_valid) : (pend_full | din_valid);
        overrun_nx   = !boundary && din_valid && pend_full;
        underrun_nx  = boundary && !pend_full && !din_valid;
    end
    // Register all state and outputs; reset parks the duty at midscale so the filter sees silence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            duty         <= MIDSCALE;
            pend         <= '0;
            pend_full    <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            duty         <= duty_nx;
            pend         <= pend_nx;
            pend_full    <= pend_full_nx;
            pwm_out      <= cnt < duty;
            period_start <= boundary;
            overrun      <= overrun_nx;
            underrun     <= underrun_nx;
        end
    end
endmodule

// File: tb/tb_pwm_audio_dac.sv
// tb_pwm_audio_dac: scoreboard bench measuring per-period high/overrun/underrun counts
module tb_pwm_audio_dac;
    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] ov;
        logic [15:0] un;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [3:0]  din_a = '0;
    logic [11:0] din_b = '0;
    logic        dv_a = 1'b0, dv_b = 1'b0;
    logic        pwm_a, ps_a, ov_a, un_a, pwm_b, ps_b, ov_b, un_b;
    int          cyc_a, cyc_b, both_a, both_b;
    int          total = 0, bad = 0;
    logic [15:0] hi_a, oc_a, uc_a, hi_b, oc_b, uc_b;
    rec_t        got_a[$], exp_a[$], got_b[$], exp_b[$];

    pwm_audio_dac #(.DATA_BITS(4)) u_a (
        .clk(clk), .rst_n(rst_a), .din(din_a), .din_valid(dv_a),
        .pwm_out(pwm_a), .period_start(ps_a), .overrun(ov_a), .underrun(un_a)
    );
    pwm_audio_dac #(.DATA_BITS(12)) u_b (
        .clk(clk), .rst_n(rst_b), .din(din_b), .din_valid(dv_b),
        .pwm_out(pwm_b), .period_start(ps_b), .overrun(ov_b), .underrun(un_b)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the next rising edge evaluates cnt = cyc mod period
    always @(posedge clk or negedge rst_a) cyc_a <= !rst_a ? 0 : cyc_a + 1;
    always @(posedge clk or negedge rst_b) cyc_b <= !rst_b ? 0 : cyc_b + 1;

    // Per-period measurement; a period closes on the sample showing period_start
    always @(negedge clk) begin
        if (!rst_a) begin
            hi_a = 0; oc_a = 0; uc_a = 0;
        end else begin
            hi_a = hi_a + 16'(pwm_a);
            oc_a = oc_a + 16'(ov_a);
            uc_a = uc_a + 16'(un_a);
            both_a = both_a + int'(ov_a & un_a);
            if (ps_a) begin
                got_a.push_back('{hi_a, oc_a, uc_a});
                hi_a = 0; oc_a = 0; uc_a = 0;
            end
        end
        if (!rst_b) begin
            hi_b = 0; oc_b = 0; uc_b = 0;
        end else begin
            hi_b = hi_b + 16'(pwm_b);
            oc_b = oc_b + 16'(ov_b);
            uc_b = uc_b + 16'(un_b);
            both_b = both_b + int'(ov_b & un_b);
            if (ps_b) begin
                got_b.push_back('{hi_b, oc_b, uc_b});
                hi_b = 0; oc_b = 0; uc_b = 0;
            end
        end
    end

    task automatic do_reset_a();
        rst_a = 1'b0;
        dv_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        got_a.delete();
        exp_a.delete();
    endtask

    task automatic wait_cyc_a(input int n);
        while (cyc_a < n) @(negedge clk);
    endtask

    task automatic strobe_a(input int n, input logic [3:0] v);
        wait_cyc_a(n);
        din_a = v;
        dv_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
    endtask

    task automatic wait_cyc_b(input int n);
        while (cyc_b < n) @(negedge clk);
    endtask

    task automatic test_reset();
        rec_t e, g;
        #1 rst_a = 1'b0;
        #2;
        total++;
        if ({pwm_a, ps_a, ov_a, un_a} !== 4'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000", {pwm_a, ps_a, ov_a, un_a});
        end
        do_reset_a();
        @(negedge clk);
        total++;
        if (pwm_a !== 1'b1) begin bad++; $display("FAIL reset_first_pwm got=%b want=1", pwm_a); end
        total++;
        if (ps_a !== 1'b0) begin bad++; $display("FAIL reset_first_ps got=%b want=0", ps_a); end
        repeat (4) exp_a.push_back('{16'd8, 16'd0, 16'd1});
        for (int i = 0; i < 100 && got_a.size() < exp_a.size(); i++) begin @(negedge clk); #1; end
        total++;
        if (got_a.size() < exp_a.size()) begin bad++; $display("FAIL reset_timeout got=%0d want=%0d periods", got_a.size(), exp_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL reset_idle hi/ov/un got=%0d/%0d/%0d want=%0d/%0d/%0d", g.hi, g.ov, g.un, e.hi, e.ov, e.un); end
        end
    endtask

    task automatic test_steady();
        rec_t e, g;
        #1 rst_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        got_b.delete();
        exp_b.push_back('{16'd2048, 16'd0, 16'd0});
        for (int k = 0; k < 3; k++) begin
            wait_cyc_b(4096 * k + 2000);
            din_b = 12'd1000;
            dv_b = 1'b1;
            @(negedge clk);
            dv_b = 1'b0;
            if (k > 0) exp_b.push_back('{16'd1000, 16'd0, 16'd0});
        end
        for (int i = 0; i < 16384 && got_b.size() < exp_b.size(); i++) begin @(negedge clk); #1; end
        total++;
        if (got_b.size() < exp_b.size()) begin bad++; $display("FAIL steady_timeout got=%0d want=%0d periods", got_b.size(), exp_b.size()); end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            e = exp_b.pop_front(); g = got_b.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL steady hi/ov/un got=%0d/%0d/%0d want=%0d/%0d/%0d", g.hi, g.ov, g.un, e.hi, e.ov, e.un); end
        end
    endtask

    task automatic test_extremes();
        rec_t e, g;
        do_reset_a();
        strobe_a(4, 4'd0);
        exp_a.push_back('{16'd8, 16'd0, 16'd0});
        strobe_a(20, 4'd15);
        exp_a.push_back('{16'd0, 16'd0, 16'd0});
        exp_a.push_back('{16'd15, 16'd0, 16'd1});
        for (int i = 0; i < 100 && got_a.size() < exp_a.size(); i++) begin @(negedge clk); #1; end
        total++;
        if (got_a.size() < exp_a.size()) begin bad++; $display("FAIL extremes_timeout got=%0d want=%0d periods", got_a.size(), exp_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL extremes hi/ov/un got=%0d/%0d/%0d want=%0d/%0d/%0d", g.hi, g.ov, g.un, e.hi, e.ov, e.un); end
        end
    endtask

    task automatic test_overrun();
        rec_t e, g;
        do_reset_a();
        strobe_a(2, 4'd3);
        strobe_a(5, 4'd9);
        total++;
        if (ov_a !== 1'b1) begin bad++; $display("FAIL overrun_pulse got=%b want=1", ov_a); end
        exp_a.push_back('{16'd8, 16'd1, 16'd0});
        exp_a.push_back('{16'd9, 16'd0, 16'd1});
        for (int i = 0; i < 100 && got_a.size() < exp_a.size(); i++) begin @(negedge clk); #1; end
        total++;
        if (got_a.size() < exp_a.size()) begin bad++; $display("FAIL overrun_timeout got=%0d want=%0d periods", got_a.size(), exp_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL overrun hi/ov/un got=%0d/%0d/%0d want=%0d/%0d/%0d", g.hi, g.ov, g.un, e.hi, e.ov, e.un); end
        end
    endtask

    task automatic test_boundary();
        rec_t e, g;
        do_reset_a();
        strobe_a(3, 4'd5);
        strobe_a(15, 4'd11);
        exp_a.push_back('{16'd8, 16'd0, 16'd0});
        exp_a.push_back('{16'd5, 16'd0, 16'd0});
        exp_a.push_back('{16'd11, 16'd0, 16'd1});
        for (int i = 0; i < 100 && got_a.size() < exp_a.size(); i++) begin @(negedge clk); #1; end
        total++;
        if (got_a.size() < exp_a.size()) begin bad++; $display("FAIL collide_timeout got=%0d want=%0d periods", got_a.size(), exp_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL collide_full hi/ov/un got=%0d/%0d/%0d want=%0d/%0d/%0d", g.hi, g.ov, g.un, e.hi, e.ov, e.un); end
        end
        do_reset_a();
        strobe_a(15, 4'd7);
        exp_a.push_back('{16'd8, 16'd0, 16'd0});
        exp_a.push_back('{16'd7, 16'd0, 16'd1});
        for (int i = 0; i < 100 && got_a.size() < exp_a.size(); i++) begin @(negedge clk); #1; end
        total++;
        if (got_a.size() < exp_a.size()) begin bad++; $display("FAIL bypass_timeout got=%0d want=%0d periods", got_a.size(), exp_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL collide_bypass hi/ov/un got=%0d/%0d/%0d want=%0d/%0d/%0d", g.hi, g.ov, g.un, e.hi, e.ov, e.un); end
        end
    endtask

    task automatic test_async_reset();
        rec_t e, g;
        do_reset_a();
        strobe_a(3, 4'd12);
        wait_cyc_a(6);
        @(posedge clk);
        #2;
        total++;
        if (pwm_a !== 1'b1) begin bad++; $display("FAIL async_pre_pwm got=%b want=1", pwm_a); end
        rst_a = 1'b0;
        #1;
        total++;
        if ({pwm_a, ps_a, ov_a, un_a} !== 4'b0) begin
            bad++;
            $display("FAIL async_outputs got=%b want=0000", {pwm_a, ps_a, ov_a, un_a});
        end
        do_reset_a();
        repeat (2) exp_a.push_back('{16'd8, 16'd0, 16'd1});
        for (int i = 0; i < 100 && got_a.size() < exp_a.size(); i++) begin @(negedge clk); #1; end
        total++;
        if (got_a.size() < exp_a.size()) begin bad++; $display("FAIL async_timeout got=%0d want=%0d periods", got_a.size(), exp_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL async_after hi/ov/un got=%0d/%0d/%0d want=%0d/%0d/%0d", g.hi, g.ov, g.un, e.hi, e.ov, e.un); end
        end
    endtask

    task automatic test_exclusive();
        total++;
        if (both_a !== 0) begin bad++; $display("FAIL exclusive_a got=%0d want=0", both_a); end
        total++;
        if (both_b !== 0) begin bad++; $display("FAIL exclusive_b got=%0d want=0", both_b); end
    endtask

    initial begin
        both_a = 0;
        both_b = 0;
        test_reset();
        test_extremes();
        test_overrun();
        test_boundary();
        test_async_reset();
        test_steady();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
